// File: rtl/led_cipher_pkg.sv
// Shared definitions for the LED cipher encrypt and decrypt paths:
// S-box tables, FSM state encoding, rotation and round-key constants.
package led_cipher_pkg;

  // Round rotation amount and round-key rotation step
  localparam logic [3:0] ROT   = 4'd5;
  localparam logic [3:0] KSTEP = 4'd3;

  // Nibble tables packed LSB-first: entry i lives in bits [4i+3:4i]
  localparam logic [63:0] SBOX_TBL     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SBOX_INV_TBL = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SBOX_INV_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [15:0] sbox16(input logic [15:0] v);
    return {sbox(v[15:12]), sbox(v[11:8]), sbox(v[7:4]), sbox(v[3:0])};
  endfunction

  function automatic logic [15:0] sbox16_inv(input logic [15:0] v);
    return {sbox_inv(v[15:12]), sbox_inv(v[11:8]), sbox_inv(v[7:4]), sbox_inv(v[3:0])};
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] a);
    logic [31:0] d;
    d = {v, v} << a;
    return d[31:16];
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] v, input logic [3:0] a);
    logic [31:0] d;
    d = {v, v} >> a;
    return d[15:0];
  endfunction

  // k_r = rotl(key, 3r mod 16) ^ r ; the 4-bit product wraps mod 16 for free
  function automatic logic [15:0] round_key(input logic [15:0] key, input logic [3:0] r);
    logic [3:0] amt;
    amt = 4'(r * KSTEP);
    return rotl16(key, amt) ^ {12'h000, r};
  endfunction

endpackage

// File: rtl/led_round_inv.sv
// One combinational inverse LED round: undo the rotation, undo the S-box
// layer, then strip the round key.
module led_round_inv
  import led_cipher_pkg::*;
(
  input  logic [15:0] i_state,
  input  logic [15:0] i_key,
  input  logic [3:0]  i_round,
  output logic [15:0] o_state
);

  logic [15:0] w_rot;
  logic [15:0] w_sub;
  logic [15:0] w_rk;

  assign w_rot   = rotr16(i_state, ROT);
  assign w_sub   = sbox16_inv(w_rot);
  assign w_rk    = round_key(i_key, i_round);
  assign o_state = w_sub ^ w_rk;

endmodule

// File: rtl/led_decipher.sv
// LED block decipher: loads key and ciphertext as four bytes, runs one
// inverse round per clock from the last round down to round 0, then
// streams the plaintext out as two bytes (high byte first).
module led_decipher
  import led_cipher_pkg::*;
#(
  parameter int NROUNDS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

  state_t      r_state;
  logic [1:0]  r_bcnt;
  logic [3:0]  r_rcnt;
  logic [15:0] r_s;
  logic [15:0] r_key;
  logic        r_osel;
  logic [15:0] w_next;

  led_round_inv u_round (
    .i_state (r_s),
    .i_key   (r_key),
    .i_round (r_rcnt),
    .o_state (w_next)
  );

  // FSM, byte/round counters and the key/state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_bcnt  <= 2'd0;
      r_rcnt  <= 4'd0;
      r_s     <= 16'h0000;
      r_key   <= 16'h0000;
      r_osel  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            r_bcnt <= r_bcnt + 2'd1;
            case (r_bcnt)
              2'd0: r_key[15:8] <= in_data;
              2'd1: r_key[7:0]  <= in_data;
              2'd2: r_s[15:8]   <= in_data;
              2'd3: begin
                r_s[7:0] <= in_data;
                r_rcnt   <= LAST_ROUND;
                r_state  <= ST_RUN;
              end
            endcase
          end
        end
        ST_RUN: begin
          r_s <= w_next;
          if (r_rcnt == 4'd0) begin
            r_state <= ST_SEND;
            r_osel  <= 1'b0;
          end else begin
            r_rcnt <= r_rcnt - 4'd1;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (r_osel) begin
              r_state <= ST_LOAD;
              r_osel  <= 1'b0;
            end else begin
              r_osel <= 1'b1;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    in_ready  = (r_state == ST_LOAD);
    out_valid = (r_state == ST_SEND);
    busy      = (r_state == ST_RUN);
    out_data  = 8'h00;
    if (r_state == ST_SEND) begin
      out_data = r_osel ? r_s[7:0] : r_s[15:8];
    end
  end

endmodule

// File: tb/tb_led_decipher.sv
// Testbench for led_decipher: a golden encrypt model produces ciphertext,
// and a per-cycle monitor predicts handshakes, latency and plaintext bytes.
module tb_led_decipher;

  localparam int NR = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;

  led_decipher #(.NROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- golden model ----------------
  int SB[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  function automatic logic [15:0] m_rotl(input logic [15:0] v, input int a);
    int x;
    x = ((int'(v) << a) | (int'(v) >> (16 - a))) & 32'hFFFF;
    return x[15:0];
  endfunction

  function automatic logic [15:0] m_rk(input logic [15:0] k, input int r);
    return m_rotl(k, (3 * r) % 16) ^ 16'(r);
  endfunction

  function automatic logic [15:0] m_enc(input logic [15:0] p, input logic [15:0] k, input int n);
    logic [15:0] s;
    int t, u;
    s = p;
    for (int r = 0; r < n; r++) begin
      t = int'(s ^ m_rk(k, r));
      u = 0;
      for (int i = 0; i < 4; i++) u = u | (SB[(t >> (4 * i)) & 15] << (4 * i));
      s = m_rotl(u[15:0], 5);
    end
    return s;
  endfunction

  // ---------------- per-cycle monitor ----------------
  logic [15:0] cur_pt = 16'h0000;
  logic [7:0]  exp_q[$];
  logic [7:0]  out_log[$];
  int          m_nb = 0;
  bit          m_wait = 1'b0;
  int          m_t4 = 0;
  bit          m_since_rst = 1'b1;
  bit          prev_hold = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(negedge clk) begin : monitor
    bit e_send, e_busy, e_load;
    logic [7:0] e_byte;
    if (rst) begin
      m_nb = 0;
      m_wait = 1'b0;
      exp_q.delete();
      prev_hold = 1'b0;
      m_since_rst = 1'b1;
    end else begin
      e_load = !m_wait;
      e_send = m_wait && (cyc >= m_t4 + 1 + NR);
      e_busy = m_wait && !e_send;
      chk("in_ready", 32'(in_ready), 32'(e_load));
      chk("out_valid", 32'(out_valid), 32'(e_send));
      chk("busy", 32'(busy), 32'(e_busy));
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (m_since_rst && !e_send) chk("idle_data", 32'(out_data), 32'h00);
      if (in_valid && e_load) begin
        m_nb++;
        if (m_nb == 4) begin
          m_nb = 0;
          m_wait = 1'b1;
          m_t4 = cyc;
          exp_q.push_back(cur_pt[15:8]);
          exp_q.push_back(cur_pt[7:0]);
        end
      end
      if (out_ready && e_send) begin
        m_since_rst = 1'b0;
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e_byte = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e_byte));
          out_log.push_back(out_data);
          if (exp_q.size() == 0) m_wait = 1'b0;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // ---------------- out_ready driver ----------------
  int or_mode = 0;  // 0: always ready, 1: random, 2: manual

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (or_mode == 0) out_ready = 1'b1;
      else if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic put_byte(input logic [7:0] b, input int gap, input bit noise);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(posedge clk); #1;
    end
    t = 0;
    while (!in_ready && t < 300) begin
      in_valid = noise;
      in_data  = 8'hAA;
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      chk("in_timeout", 32'(t), 32'd0);
    end else begin
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
    end
    in_valid = noise;
    in_data  = noise ? 8'hAA : 8'h00;
  endtask

  task automatic run_block(input logic [15:0] k, input logic [15:0] p,
                           input int g0, input int g1, input int g2, input int g3,
                           input bit noise);
    logic [15:0] ct;
    ct = m_enc(p, k, NR);
    cur_pt = p;
    put_byte(k[15:8], g0, noise);
    put_byte(k[7:0], g1, noise);
    put_byte(ct[15:8], g2, noise);
    put_byte(ct[7:0], g3, noise);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_wait || m_nb != 0) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_timeout", 32'(m_wait || m_nb != 0), 32'd0);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ov_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] k, p;

    // Pin the model with hand-derived values
    chk("model_enc1", 32'(m_enc(16'h0000, 16'h0000, 1)), 32'h9999);
    chk("model_enc2", 32'(m_enc(16'h0000, 16'h0000, 2)), 32'hDC7D);
    chk("model_rk1", 32'(m_rk(16'hBEEF, 1)), 32'hF77C);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Round trip with known key/plaintext
    or_mode = 0;
    run_block(16'hBEEF, 16'h1234, 0, 0, 0, 0, 1'b0);
    wait_idle();
    chk("rt_hi", 32'(out_log[out_log.size() - 2]), 32'h12);
    chk("rt_lo", 32'(out_log[out_log.size() - 1]), 32'h34);

    // Backpressure while sending
    or_mode = 2;
    out_ready = 1'b0;
    run_block(16'h1357, 16'hA5C3, 0, 0, 0, 0, 1'b0);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", 32'(out_data), 32'hA5);
      chk("bp_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second", 32'(out_data), 32'hC3);
    @(posedge clk); #1;
    chk("bp_ready_after", 32'(in_ready), 32'd1);
    or_mode = 0;

    // Input gaps: in_valid 1,0,0,1,0,1,1
    run_block(16'h0000, 16'h0000, 0, 2, 1, 0, 1'b0);
    wait_idle();
    chk("gap_hi", 32'(out_log[out_log.size() - 2]), 32'h00);
    chk("gap_lo", 32'(out_log[out_log.size() - 1]), 32'h00);

    // Ignored input during RUN/SEND
    run_block(16'h0F1E, 16'hCAFE, 0, 0, 0, 0, 1'b1);
    run_block(16'h7777, 16'h0101, 0, 0, 0, 0, 1'b1);
    in_valid = 1'b0;
    in_data  = 8'h00;
    wait_idle();
    chk("ign_hi", 32'(out_log[out_log.size() - 2]), 32'h01);
    chk("ign_lo", 32'(out_log[out_log.size() - 1]), 32'h01);

    // Reset mid-RUN (third round)
    run_block(16'h4321, 16'h9876, 0, 0, 0, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_busy", 32'(busy), 32'd1);
    do_reset();

    // Reset mid-SEND after one output byte
    run_block(16'h2468, 16'h1357, 0, 0, 0, 0, 1'b0);
    wait_out_valid();
    @(posedge clk); #1;
    chk("midsend_lo", 32'(out_data), 32'h57);
    do_reset();

    // Block after resets decrypts correctly
    run_block(16'hBEEF, 16'h1234, 0, 0, 0, 0, 1'b0);
    wait_idle();
    chk("post_rst_hi", 32'(out_log[out_log.size() - 2]), 32'h12);
    chk("post_rst_lo", 32'(out_log[out_log.size() - 1]), 32'h34);

    // Random sweep with input gaps and output stalls
    or_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      k = 16'($urandom);
      p = 16'($urandom);
      run_block(k, p, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end
    wait_idle();
    or_mode = 0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
